imem_stream_loader: RTL and testbench

//  Upstream boot stage for the pipelined riscv core: accepts a byte stream, packs it into 32-bit

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/imem_stream_loader_packer.sv | 51 +++++
 rtl/imem_stream_loader.sv | 142 ++++++++++++++
 tb/tb_imem_stream_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the riscv boot path: data width, default instruction
// memory depth, loader state encoding and the header range check.
package riscv_pkg;

   localparam int XLEN           = 32;
   localparam int IMEM_DEPTH_DEF = 32;

   typedef enum logic [2:0] {
      LD_IDLE = 3'd0,
      LD_HDR  = 3'd1,
      LD_DATA = 3'd2,
      LD_CSUM = 3'd3,
      LD_DONE = 3'd4,
      LD_ERR  = 3'd5
   } ld_state_e;

   // A header is a word count; zero or more than the memory holds is rejected.
   function automatic logic hdr_ok(input logic [7:0] n, input int depth);
      return (n != 8'd0) && (32'(n) <= depth);
   endfunction

endpackage

// File: rtl/imem_stream_loader_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word_valid_o pulses
// the cycle after the 4th byte, while word_o still holds the assembled word.
module imem_stream_loader_packer
   import riscv_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            byte_vld_i,
   input  logic [7:0]      byte_i,
   output logic            last_byte_o,
   output logic            word_valid_o,
   output logic [XLEN-1:0] word_o
);

   logic [1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] word_q, word_d;
   logic            wv_q, wv_d;

   assign last_byte_o  = (cnt_q == 2'd3);
   assign word_valid_o = wv_q;
   assign word_o       = word_q;

   // Bytes enter at the top, so byte 0 settles in [7:0] after four shifts.
   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      wv_d   = 1'b0;
      if (clr_i) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (byte_vld_i) begin
         cnt_d  = cnt_q + 2'd1;
         word_d = {byte_i, word_q[XLEN-1:8]};
         wv_d   = last_byte_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         word_q <= '0;
         wv_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
         wv_q   <= wv_d;
      end
   end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: header byte N, then 4N image bytes written to instruction memory;
// holds core_rst_o until the image is complete. Define CHECKSUM_EN for a sum trailer.
module imem_stream_loader
   import riscv_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   input  logic [7:0]        in_data_i,
   output logic              in_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   output logic              core_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int CNT_W = ADDR_W + 1;

   ld_state_e         state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d, wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              accept, restart, all_in;
   logic              last_byte, word_valid;
   logic [XLEN-1:0]   word;

   // all_in: the final byte of the image has been taken, so stop accepting
   // even though the last write is still one cycle away.
   assign all_in     = (wcnt_q == n_q);
   assign in_ready_o = (state_q == LD_HDR) || (state_q == LD_CSUM) ||
                       ((state_q == LD_DATA) && !all_in);
   assign accept     = in_valid_i && in_ready_o;

   imem_stream_loader_packer u_packer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (restart),
      .byte_vld_i   (accept && (state_q == LD_DATA)),
      .byte_i       (in_data_i),
      .last_byte_o  (last_byte),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

`ifdef CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
`endif

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      restart = 1'b0;
`ifdef CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         LD_IDLE, LD_DONE, LD_ERR: begin
            if (start_i) begin
               state_d = LD_HDR;
               wcnt_d  = '0;
               addr_d  = '0;
               restart = 1'b1;
`ifdef CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         LD_HDR: begin
            if (accept) begin
               if (hdr_ok(in_data_i, IMEM_DEPTH)) begin
                  state_d = LD_DATA;
                  n_d     = in_data_i[CNT_W-1:0];
               end else begin
                  state_d = LD_ERR;
               end
            end
         end
         LD_DATA: begin
            if (accept) begin
               if (last_byte) wcnt_d = wcnt_q + CNT_W'(1);
`ifdef CHECKSUM_EN
               sum_d = sum_q + in_data_i;
`endif
            end
            if (word_valid) begin
               if (all_in) begin
`ifdef CHECKSUM_EN
                  state_d = LD_CSUM;
`else
                  state_d = LD_DONE;
`endif
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
`ifdef CHECKSUM_EN
         LD_CSUM: begin
            if (accept) state_d = (in_data_i == sum_q) ? LD_DONE : LD_ERR;
         end
`endif
         default: state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= LD_IDLE;
         n_q     <= '0;
         wcnt_q  <= '0;
         addr_q  <= '0;
`ifdef CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
`ifdef CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign mem_we_o    = word_valid;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = word;
   assign core_rst_o  = (state_q != LD_DONE);
   assign busy_o      = (state_q == LD_HDR) || (state_q == LD_DATA) || (state_q == LD_CSUM);
   assign done_o      = (state_q == LD_DONE);
   assign err_o       = (state_q == LD_ERR);

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: cycle table for the short flows,
// hand sequences for multi-word, gapped, reset-abort and checksum loads.
module tb_imem_stream_loader;

   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, core_rst, busy, done, err;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   imem_stream_loader dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .core_rst_o  (core_rst),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // write log, sampled mid-cycle
   logic [4:0]  log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];
   logic        log_crst[$];
   always @(negedge clk) begin
      if (mem_we) begin
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
         log_cyc.push_back(cyc);
         log_crst.push_back(core_rst);
      end
   end

   typedef struct {
      logic        start, vld;
      logic [7:0]  d;
      logic        rdy, we, crst, bsy, dn, er;
      logic [4:0]  addr;
      logic [31:0] wdata;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic s, v, input logic [7:0] d,
                               input logic rdy, we, crst, bsy, dn, er,
                               input logic [4:0] a, input logic [31:0] w);
      vec_t x;
      x.start = s; x.vld = v; x.d = d;
      x.rdy = rdy; x.we = we; x.crst = crst; x.bsy = bsy; x.dn = dn; x.er = er;
      x.addr = a; x.wdata = w;
      tbl.push_back(x);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      in_valid = 1'b1; in_data = b;
      while (!in_ready && t < 50) begin tick(); t++; end
      if (!in_ready) check("send_byte ready timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic wait_end(input string name);
      int t = 0;
      while (!(done || err) && t < 300) begin tick(); t++; end
      check(name, {63'd0, done || err}, 64'd1);
   endtask

   task automatic clear_log();
      log_addr.delete(); log_data.delete(); log_cyc.delete(); log_crst.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Load an image of n words from img, optionally with gaps; checks writes.
   task automatic load_and_check(input string name, input int n, input logic [31:0] img[32],
                                 input logic gaps, input logic spacing);
      logic [7:0] sum = 8'h00;
      clear_log();
      pulse_start();
      send_byte(8'(n));
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) begin
            logic [31:0] word = img[w];
            logic [7:0] b = word[8*k +: 8];
            sum = sum + b;
            if (gaps) idle($urandom_range(0, 2));
            send_byte(b);
         end
      end
`ifdef CHECKSUM_EN
      send_byte(sum);
`endif
      wait_end({name, " end"});
      check({name, " done"}, {62'd0, done, err}, 64'h2);
      check({name, " core_rst"}, {63'd0, core_rst}, 64'd0);
      check({name, " wr count"}, 64'(log_addr.size()), 64'(n));
      for (int i = 0; i < log_addr.size() && i < n; i++) begin
         check($sformatf("%s wr%0d addr", name, i), 64'(log_addr[i]), 64'(i));
         check($sformatf("%s wr%0d data", name, i), 64'(log_data[i]), 64'(img[i]));
         check($sformatf("%s wr%0d core_rst", name, i), 64'(log_crst[i]), 64'd1);
         if (spacing && i > 0)
            check($sformatf("%s wr%0d spacing", name, i), 64'(log_cyc[i] - log_cyc[i-1]), 64'd4);
      end
      check({name, " final addr"}, 64'(mem_addr), 64'(n - 1));
   endtask

   initial begin
      logic [31:0] img[32];

      // reset values
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) tick();
      check("reset outputs",
            {in_ready, mem_we, core_rst, busy, done, err, mem_addr, mem_wdata},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
      rst = 1'b0;

      // single-word load, DONE refusal, bad headers and recovery
      add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 8'h01, 1, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 8'h13, 1, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 8'h00, 1, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 8'h00, 1, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 8'h00, 1, 0, 1, 1, 0, 0, 0, 0);
      add(0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 32'h0000_0013);
`ifdef CHECKSUM_EN
      add(0, 1, 8'h13, 1, 0, 1, 1, 0, 0, 0, 0);
`endif
      add(0, 1, 8'hAA, 0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 1, 8'h00, 1, 0, 1, 1, 0, 0, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0);
      add(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0);
      add(0, 1, 8'h21, 1, 0, 1, 1, 0, 0, 0, 0);
      add(0, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0);
      add(1, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 0);
      add(0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         start = tbl[i].start; in_valid = tbl[i].vld; in_data = tbl[i].d;
         #1;
         check($sformatf("vec%0d", i),
               {in_ready, mem_we, core_rst, busy, done, err, mem_addr, mem_we ? mem_wdata : 32'd0},
               {tbl[i].rdy, tbl[i].we, tbl[i].crst, tbl[i].bsy, tbl[i].dn, tbl[i].er,
                tbl[i].addr, tbl[i].we ? tbl[i].wdata : 32'd0});
         tick();
      end
      start = 1'b0; in_valid = 1'b0;

      // three words back-to-back, then DONE refuses bytes
      do_reset();
      img[0] = 32'h4433_2211; img[1] = 32'h8877_6655; img[2] = 32'hCCBB_AA99;
      load_and_check("n3", 3, img, 1'b0, 1'b1);
      in_valid = 1'b1; in_data = 8'h5A; #1;
      check("n3 ready in DONE", {63'd0, in_ready}, 64'd0);
      tick(); in_valid = 1'b0;

      // full 32-word image with random bubbles
      do_reset();
      for (int i = 0; i < 32; i++) img[i] = $urandom;
      load_and_check("n32", 32, img, 1'b1, 1'b0);

      // reset after 6 of 8 data bytes, then clean reload
      do_reset();
      pulse_start();
      send_byte(8'd2);
      for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i));
      rst = 1'b1; tick(); rst = 1'b0;
      #1;
      check("abort idle", {60'd0, busy, done, err, in_ready}, 64'd0);
      img[0] = 32'hDEAD_BEEF; img[1] = 32'h0BAD_F00D;
      load_and_check("reload", 2, img, 1'b0, 1'b1);

`ifdef CHECKSUM_EN
      // trailer match and mismatch
      do_reset();
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h13);
      wait_end("csum ok end");
      check("csum ok", {61'd0, done, err, core_rst}, 64'h4);
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h14);
      wait_end("csum bad end");
      check("csum bad", {61'd0, done, err, core_rst}, 64'h3);
      repeat (3) tick();
      check("csum bad hold", {63'd0, core_rst}, 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
